// File: rtl/muldiv_pkg.sv
// Shared encodings for the mul/div sequencer: operation codes, FSM states
// and the LO value reported for a divide by zero.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL      = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Both divide encodings share the upper op bit.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul32.sv
// Signed/unsigned 32x32->64 multiplier.
// Defining MULDIV_MUL_PIPE_EN registers the product (one cycle of latency).
module mul32 (
`ifdef MULDIV_MUL_PIPE_EN
    input  logic        clka,
    input  logic        rst,
`endif
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [63:0] product
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] full;

    // Sign-extending to 64 bits makes the low 64 bits of one product correct for both modes.
    assign ext_a = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
    assign ext_b = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
    assign full  = ext_a * ext_b;

`ifdef MULDIV_MUL_PIPE_EN
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            product <= '0;
        end else begin
            product <= full;
        end
    end
`else
    assign product = full;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO mul/div sequencer: runs the local multiplier, drives the external divider
// with a watchdog, and stalls the pipeline. MULDIV_MUL_PIPE_EN selects a 2-cycle multiply.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DIV_MAX_CYCLES = 40
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic        div_annul_o,
    output logic [31:0] div_opa_o,
    output logic [31:0] div_opb_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o
);

    localparam int CW = $clog2(DIV_MAX_CYCLES + 1);

    state_t        state;
    state_t        state_next;
    logic [31:0]   opa_q;
    logic [31:0]   opb_q;
    logic          signed_q;
    logic [CW-1:0] wd_cnt;
    logic          wd_hit;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [63:0]   product;
    logic          stall;
    logic          start;
    logic          annul;
    logic          tmo;
    logic          hilo_load;
    logic [63:0]   hilo_next;

    mul32 u_mul32 (
`ifdef MULDIV_MUL_PIPE_EN
        .clka      (clka),
        .rst       (rst),
`endif
        .a         (src_a_i),
        .b         (src_b_i),
        .is_signed (op_i == OP_MULT),
        .product   (product)
    );

    assign wd_hit = (wd_cnt == CW'(DIV_MAX_CYCLES - 1));

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        tmo        = 1'b0;
        hilo_load  = 1'b0;
        hilo_next  = '0;
        case (state)
            IDLE: begin
                if (op_valid_i && !flush_i) begin
                    stall = 1'b1;
                    if (op_is_div(op_i)) begin
                        if (src_b_i != '0) begin
                            start      = 1'b1;
                            state_next = DIV_WAIT;
                        end else begin
                            hilo_load  = 1'b1;
                            hilo_next  = {src_a_i, DIV_ZERO_LO};
                            state_next = DONE;
                        end
                    end else begin
`ifdef MULDIV_MUL_PIPE_EN
                        state_next = MUL;
`else
                        hilo_load  = 1'b1;
                        hilo_next  = product;
                        state_next = DONE;
`endif
                    end
                end
            end
            MUL: begin
                stall = 1'b1;
                if (flush_i) begin
                    state_next = IDLE;
                end else begin
                    hilo_load  = 1'b1;
                    hilo_next  = product;
                    state_next = DONE;
                end
            end
            // Flush beats a same-cycle ready; ready beats the watchdog.
            DIV_WAIT: begin
                stall = 1'b1;
                if (flush_i) begin
                    annul      = 1'b1;
                    state_next = IDLE;
                end else if (div_ready_i) begin
                    hilo_load  = 1'b1;
                    hilo_next  = div_result_i;
                    state_next = DONE;
                end else if (wd_hit) begin
                    annul      = 1'b1;
                    tmo        = 1'b1;
                    hilo_load  = 1'b1;
                    hilo_next  = '0;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            signed_q <= 1'b0;
            wd_cnt   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                opa_q    <= src_a_i;
                opb_q    <= src_b_i;
                signed_q <= (op_i == OP_DIV);
                wd_cnt   <= '0;
            end else if (state == DIV_WAIT) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (hilo_load) begin
                {hi_q, lo_q} <= hilo_next;
            end
        end
    end

    // Combinational IDLE outputs are masked so that everything reads 0 while reset is held.
    assign stall_o      = stall && !rst;
    assign div_start_o  = start && !rst;
    assign div_annul_o  = annul;
    assign timeout_o    = tmo;
    assign div_opa_o    = div_start_o ? src_a_i : opa_q;
    assign div_opb_o    = div_start_o ? src_b_i : opb_q;
    assign div_signed_o = div_start_o ? (op_i == OP_DIV) : signed_q;
    assign hilo_we_o    = (state == DONE);
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table, directed corner sequences,
// and randomized ops against an arithmetic model; a second instance uses an 8-cycle watchdog.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_MUL_PIPE_EN
    localparam int MUL_STALL = 2;
`else
    localparam int MUL_STALL = 1;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_stall;
        int          exp_starts;
    } vec_t;

    logic        clka = 1'b0;
    logic        rst;
    logic        op_valid_i;
    logic [1:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        flush_i;
    logic        div_ready_i;
    logic [63:0] div_result_i;

    logic        stall_o, div_start_o, div_signed_o, div_annul_o, hilo_we_o, timeout_o;
    logic [31:0] div_opa_o, div_opb_o, hi_o, lo_o;
    logic        w_stall, w_start, w_signed, w_annul, w_we, w_timeout;
    logic [31:0] w_opa, w_opb, w_hi, w_lo;

    int checks = 0;
    int errors = 0;

    vec_t        vecs [10];
    int          g_stalls, g_starts, e_stall, e_starts, r_lat;
    logic        g_done, g_ok;
    logic [31:0] g_hi, g_lo, e_hi, e_lo, r_a, r_b, hi_before;
    logic [1:0]  r_op;
    int          annul_cnt, we_cnt, busy_cnt, first_to, to_cnt, done_at;
    logic        s0, s1, s2;
    logic [63:0] w_hilo_at;

    muldiv_ctrl dut (
        .clka(clka), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i), .stall_o(stall_o),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_annul_o(div_annul_o),
        .div_opa_o(div_opa_o), .div_opb_o(div_opb_o), .div_ready_i(div_ready_i),
        .div_result_i(div_result_i), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o),
        .timeout_o(timeout_o)
    );

    muldiv_ctrl #(.DIV_MAX_CYCLES(8)) dut_wd (
        .clka(clka), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i), .stall_o(w_stall),
        .div_start_o(w_start), .div_signed_o(w_signed), .div_annul_o(w_annul),
        .div_opa_o(w_opa), .div_opb_o(w_opb), .div_ready_i(div_ready_i),
        .div_result_i(div_result_i), .hilo_we_o(w_we), .hi_o(w_hi), .lo_o(w_lo),
        .timeout_o(w_timeout)
    );

    always #5 clka = ~clka;

    initial begin
        #500000;
        $display("[TB] FAIL global_time_limit got=expired expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Behaviour of the external divider: {remainder, quotient}.
    function automatic logic [63:0] refDiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sq, sr;
        if (op == OP_DIV) begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input int lat, output logic [31:0] hi, output logic [31:0] lo,
                                     output int stall, output int starts);
        longint      sp;
        logic [63:0] ua, ub, up;
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op == OP_MULT) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {hi, lo} = sp;
            stall = MUL_STALL;
            starts = 0;
        end else if (op == OP_MULTU) begin
            up = ua * ub;
            {hi, lo} = up;
            stall = MUL_STALL;
            starts = 0;
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            stall = 1;
            starts = 0;
        end else begin
            {hi, lo} = refDiv(op, a, b);
            stall = lat + 1;
            starts = 1;
        end
    endfunction

    // Runs one op from IDLE, acting as the divider; begins and ends just after a falling edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int lat, output int stalls, output int starts,
                                 output logic done, output logic [31:0] hi, output logic [31:0] lo,
                                 output logic opnd_ok);
        logic [63:0] res;
        int          start_cyc;
        res = (op_is_div(op) && b != 32'd0) ? refDiv(op, a, b) : 64'd0;
        stalls = 0; starts = 0; done = 1'b0; hi = '0; lo = '0; opnd_ok = 1'b1; start_cyc = -1;
        op_valid_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            div_ready_i  = (start_cyc >= 0 && c == start_cyc + lat);
            div_result_i = div_ready_i ? res : 64'd0;
            #1;
            if (stall_o) stalls++;
            if (div_start_o) begin
                starts++;
                if (start_cyc < 0) start_cyc = c;
                if (div_signed_o !== (op == OP_DIV)) opnd_ok = 1'b0;
            end
            if (start_cyc >= 0 && !hilo_we_o && (div_opa_o !== a || div_opb_o !== b)) opnd_ok = 1'b0;
            if (hilo_we_o) begin
                done = 1'b1;
                hi = hi_o;
                lo = lo_o;
                op_valid_i = 1'b0;
            end
            @(negedge clka);
        end
        op_valid_i = 1'b0;
        div_ready_i = 1'b0;
    endtask

    task automatic checkOp(input string name, input logic [31:0] ehi, input logic [31:0] elo,
                           input int estall, input int estarts);
        checkOutput({name, "_done"}, {63'b0, g_done}, 64'd1);
        checkOutput({name, "_hilo"}, {g_hi, g_lo}, {ehi, elo});
        checkOutput({name, "_stall_cycles"}, 64'(g_stalls), 64'(estall));
        checkOutput({name, "_start_pulses"}, 64'(g_starts), 64'(estarts));
        checkOutput({name, "_operands"}, {63'b0, g_ok}, 64'd1);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        repeat (2) @(negedge clka);
        rst = 1'b0;
        @(negedge clka);
    endtask

    initial begin
        vecs[0] = '{OP_DIV,   32'd100,        32'd7,          34, 32'd2,          32'd14,         35,        1};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD,  32'd5,          0,  32'hFFFF_FFFF,  32'hFFFF_FFF1,  MUL_STALL, 0};
        vecs[2] = '{OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0,  32'hFFFF_FFFE,  32'h0000_0001,  MUL_STALL, 0};
        vecs[3] = '{OP_DIVU,  32'd9,          32'd0,          5,  32'd9,          32'hFFFF_FFFF,  1,         0};
        vecs[4] = '{OP_DIVU,  32'd100,        32'd7,          1,  32'd2,          32'd14,         2,         1};
        vecs[5] = '{OP_DIV,   32'hFFFF_FF9C,  32'd7,          3,  32'hFFFF_FFFE,  32'hFFFF_FFF2,  4,         1};
        vecs[6] = '{OP_MULTU, 32'h0001_0000,  32'h0001_0000,  0,  32'd1,          32'd0,          MUL_STALL, 0};
        vecs[7] = '{OP_DIV,   32'd5,          32'd0,          5,  32'd5,          32'hFFFF_FFFF,  1,         0};
        vecs[8] = '{OP_DIVU,  32'hFFFF_FFFF,  32'd2,          2,  32'd1,          32'h7FFF_FFFF,  3,         1};
        vecs[9] = '{OP_MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0,  32'd0,          32'd1,          MUL_STALL, 0};

        // A qualifying divide is presented during reset; every output must still read 0.
        rst = 1'b1;
        op_valid_i = 1'b1; op_i = OP_DIV; src_a_i = 32'd5; src_b_i = 32'd7;
        flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = '0;
        repeat (2) @(negedge clka);
        #1;
        checkOutput("reset_outputs", {63'b0, |{stall_o, div_start_o, div_signed_o, div_annul_o, hilo_we_o,
                    timeout_o, hi_o, lo_o, div_opa_o, div_opb_o}}, 64'd0);
        checkOutput("reset_outputs_wd", {63'b0, |{w_stall, w_start, w_signed, w_annul, w_we, w_timeout,
                    w_hi, w_lo, w_opa, w_opb}}, 64'd0);
        op_valid_i = 1'b0;
        @(negedge clka);
        rst = 1'b0;
        @(negedge clka);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
                          g_stalls, g_starts, g_done, g_hi, g_lo, g_ok);
            checkOp($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_stall, vecs[i].exp_starts);
        end

        // Flush in DIV_WAIT at cycle 10, then a new divide immediately behind it.
        annul_cnt = 0; we_cnt = 0; s0 = 1'b0;
        op_valid_i = 1'b1; op_i = OP_DIV; src_a_i = 32'd50; src_b_i = 32'd3;
        for (int c = 0; c <= 10; c++) begin
            if (c == 1) op_valid_i = 1'b0;
            flush_i = (c == 10);
            #1;
            if (div_annul_o) annul_cnt++;
            if (hilo_we_o) we_cnt++;
            if (c == 10) s0 = div_annul_o;
            @(negedge clka);
        end
        flush_i = 1'b0;
        checkOutput("flush_annul_at_cycle10", {63'b0, s0}, 64'd1);
        checkOutput("flush_annul_count", 64'(annul_cnt), 64'd1);
        checkOutput("flush_no_write", 64'(we_cnt), 64'd0);
        applyStimulus(OP_DIV, 32'd50, 32'd3, 5, g_stalls, g_starts, g_done, g_hi, g_lo, g_ok);
        checkOp("div_after_flush", 32'd2, 32'd16, 6, 1);

        // Ready and flush in the same DIV_WAIT cycle: the result is dropped.
        annul_cnt = 0; we_cnt = 0; s0 = 1'b0;
        hi_before = hi_o;
        op_valid_i = 1'b1; op_i = OP_DIVU; src_a_i = 32'd40; src_b_i = 32'd5;
        for (int c = 0; c <= 5; c++) begin
            if (c == 1) op_valid_i = 1'b0;
            flush_i = (c == 3);
            div_ready_i = (c == 3);
            div_result_i = (c == 3) ? {32'd0, 32'd8} : 64'd0;
            #1;
            if (div_annul_o) annul_cnt++;
            if (hilo_we_o) we_cnt++;
            if (c == 3) s0 = div_annul_o;
            @(negedge clka);
        end
        flush_i = 1'b0; div_ready_i = 1'b0;
        checkOutput("ready_flush_annul", {63'b0, s0}, 64'd1);
        checkOutput("ready_flush_no_write", 64'(we_cnt), 64'd0);
        checkOutput("ready_flush_hi_kept", {32'b0, hi_o}, {32'b0, hi_before});

        // Flush in IDLE blocks the start; a stray ready in IDLE is ignored.
        op_valid_i = 1'b1; flush_i = 1'b1; op_i = OP_DIV; src_a_i = 32'd10; src_b_i = 32'd2;
        #1;
        s0 = div_start_o; s1 = stall_o;
        @(negedge clka);
        op_valid_i = 1'b0; flush_i = 1'b0;
        div_ready_i = 1'b1; div_result_i = {32'd7, 32'd7};
        busy_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (stall_o || div_start_o || hilo_we_o) busy_cnt++;
            @(negedge clka);
        end
        div_ready_i = 1'b0; div_result_i = '0;
        checkOutput("idle_flush_no_start", {62'b0, s0, s1}, 64'd0);
        checkOutput("idle_ready_ignored", 64'(busy_cnt), 64'd0);

        // op_valid held through DONE: DONE still returns to IDLE (which then stalls anew).
        done_at = -1; s0 = 1'b1; s1 = 1'b1; s2 = 1'b0;
        op_valid_i = 1'b1; op_i = OP_MULTU; src_a_i = 32'd6; src_b_i = 32'd7;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (done_at >= 0 && c == done_at + 1) begin
                s1 = hilo_we_o;
                s2 = stall_o;
                op_valid_i = 1'b0;
            end
            if (hilo_we_o && done_at < 0) begin
                done_at = c;
                s0 = stall_o;
            end
            @(negedge clka);
        end
        op_valid_i = 1'b0;
        checkOutput("done_cycle", 64'(done_at), 64'(MUL_STALL));
        checkOutput("done_no_stall", {63'b0, s0}, 64'd0);
        checkOutput("done_then_idle", {62'b0, s1, s2}, 64'd1);

`ifdef MULDIV_MUL_PIPE_EN
        // Flush while in MUL: no write and no divider annul.
        annul_cnt = 0; we_cnt = 0;
        op_valid_i = 1'b1; op_i = OP_MULT; src_a_i = 32'd3; src_b_i = 32'd4;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) op_valid_i = 1'b0;
            flush_i = (c == 1);
            #1;
            if (div_annul_o) annul_cnt++;
            if (hilo_we_o) we_cnt++;
            @(negedge clka);
        end
        flush_i = 1'b0;
        checkOutput("mul_flush_no_write", 64'(we_cnt), 64'd0);
        checkOutput("mul_flush_no_annul", 64'(annul_cnt), 64'd0);
`endif

        for (int i = 0; i < 30; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 7) == 0) r_b = 32'd0;
            if (r_op == OP_DIV && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) r_b = 32'd1;
            r_lat = $urandom_range(1, 30);
            refModel(r_op, r_a, r_b, r_lat, e_hi, e_lo, e_stall, e_starts);
            applyStimulus(r_op, r_a, r_b, r_lat, g_stalls, g_starts, g_done, g_hi, g_lo, g_ok);
            checkOp($sformatf("rand%0d_op%0d", i, r_op), e_hi, e_lo, e_stall, e_starts);
        end

        // Watchdog on the 8-cycle instance; leave it holding nonzero HI/LO first.
        pulseReset();
        applyStimulus(OP_DIVU, 32'd9, 32'd0, 1, g_stalls, g_starts, g_done, g_hi, g_lo, g_ok);
        first_to = -1; to_cnt = 0; s0 = 1'b0; s1 = 1'b0; w_hilo_at = 64'hDEAD_BEEF_DEAD_BEEF;
        op_valid_i = 1'b1; op_i = OP_DIV; src_a_i = 32'd77; src_b_i = 32'd5;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) op_valid_i = 1'b0;
            #1;
            if (first_to >= 0 && c == first_to + 1) begin
                s1 = w_we;
                w_hilo_at = {w_hi, w_lo};
            end
            if (w_timeout) begin
                to_cnt++;
                if (first_to < 0) begin
                    first_to = c;
                    s0 = w_annul;
                end
            end
            @(negedge clka);
        end
        checkOutput("wd_timeout_cycle", 64'(first_to), 64'd8);
        checkOutput("wd_timeout_count", 64'(to_cnt), 64'd1);
        checkOutput("wd_annul_with_timeout", {63'b0, s0}, 64'd1);
        checkOutput("wd_write_after_timeout", {63'b0, s1}, 64'd1);
        checkOutput("wd_hilo_zero", w_hilo_at, 64'd0);
        checkOutput("main_no_timeout_yet", {62'b0, timeout_o, hilo_we_o}, 64'd0);

        // Main instance is still in DIV_WAIT: reset must clear outputs with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", {63'b0, |{stall_o, div_start_o, div_signed_o, div_annul_o,
                    hilo_we_o, timeout_o, hi_o, lo_o, div_opa_o, div_opb_o}}, 64'd0);
        @(negedge clka);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_idle", {62'b0, stall_o, hilo_we_o}, 64'd0);
        @(negedge clka);
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 3, g_stalls, g_starts, g_done, g_hi, g_lo, g_ok);
        checkOp("div_after_reset", 32'd2, 32'd14, 4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter DIV_MAX_CYCLES, default 40, which sets the watchdog limit in DIV_WAIT cycles.
REQ-002 SHALL have port clka  in  1  as the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  as the reset, asynchronous and active-high.
REQ-004 SHALL have port op_valid_i  in  1  marking a mul/div instruction in E stage that is not flushed.
REQ-005 SHALL have port op_i  in  2  with encoding 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports src_a_i, src_b_i  in  32  carrying the forwarded E-stage operands.
REQ-007 SHALL have port flush_i  in  1  which cancels the in-flight operation.
REQ-008 SHALL have port stall_o  out  1  as the pipeline stall request to the hazard unit.
REQ-009 SHALL have divider handshake ports: div_start_o out 1, div_signed_o out 1, div_annul_o out 1, div_opa_o out 32, div_opb_o out 32, div_ready_i in 1, div_result_i in 64 ({remainder, quotient}).
REQ-010 SHALL have ports hilo_we_o out 1, hi_o out 32, lo_o out 32, timeout_o out 1.

Function
REQ-011 SHALL implement the states IDLE, MUL, DIV_WAIT and DONE.
REQ-012 IDLE, op_valid_i=1, flush_i=0, DIV/DIVU, src_b_i!=0 SHALL: latch operands, pulse div_start_o for 1 cycle, set div_signed_o = (op_i==DIV), and go to DIV_WAIT.
REQ-013 IDLE with DIV/DIVU and src_b_i==0 SHALL: not start the divider, set hi=src_a_i and lo=32'hFFFF_FFFF, and go to DONE.
REQ-014 IDLE with MULT/MULTU SHALL register the 64-bit product (signed for MULT, zero-extended for MULTU) into {hi,lo} and go to DONE; see REQ-026 for the MUL path.
REQ-015 DIV_WAIT with div_ready_i=1 SHALL capture hi=div_result_i[63:32] and lo=div_result_i[31:0], then go to DONE.
REQ-016 stall_o SHALL be combinational: 1 in IDLE when a qualifying op is present, 1 in MUL and in DIV_WAIT, and 0 in DONE.
REQ-017 DONE SHALL assert hilo_we_o for exactly 1 cycle with hi_o/lo_o valid, then go to IDLE unconditionally; op_valid_i in DONE SHALL be ignored (no restart).
REQ-018 div_opa_o/div_opb_o SHALL remain stable from the start pulse until leaving DIV_WAIT.
REQ-019 flush_i=1 in DIV_WAIT or MUL SHALL: pulse div_annul_o for 1 cycle (DIV_WAIT only), go to IDLE, and produce no hilo_we_o; flush_i=1 in IDLE SHALL block the start.
REQ-020 The watchdog counter SHALL clear on start and increment each DIV_WAIT cycle; on reaching DIV_MAX_CYCLES with no ready it SHALL pulse div_annul_o and timeout_o, set hi=lo=0, and go to DONE.
REQ-021 div_ready_i and flush_i asserted in the same cycle SHALL resolve in favour of flush (result discarded).
REQ-022 div_ready_i asserted outside DIV_WAIT SHALL be ignored.

Reset
REQ-023 rst SHALL force IDLE asynchronously, including mid-operation, with no annul pulse issued.
REQ-024 Under reset all outputs SHALL be 0: stall_o, div_start_o, div_signed_o, div_annul_o, hilo_we_o, timeout_o, hi_o, lo_o, div_opa_o, div_opb_o; the watchdog counter SHALL be 0.

Configuration
REQ-025 Macro MULDIV_MUL_PIPE_EN SHALL select the multiplier timing.
REQ-026 With MULDIV_MUL_PIPE_EN defined: IDLE -> MUL -> DONE, with the multiplier registered internally; stall_o stays high for 2 cycles.
REQ-027 Without MULDIV_MUL_PIPE_EN: the MUL state is never entered; IDLE -> DONE; stall_o stays high for 1 cycle.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op_i encodings, the state enum, and the divide-by-zero LO constant 32'hFFFF_FFFF.
REQ-029 Sub-module mul32 SHALL contain the signed/unsigned 32x32->64 multiplier, with its optional pipeline register under MULDIV_MUL_PIPE_EN.
REQ-030 The divider SHALL remain external; muldiv_ctrl only sequences it.

Verification
REQ-031 DIV 100/7 with div_ready_i returned 34 cycles after start -> stall_o high 35 cycles; then hilo_we_o=1, hi=2, lo=14.
REQ-032 MULT -3 x 5 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1; MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001; check stall length in both macro builds.
REQ-033 DIVU 9/0 -> no div_start_o, DONE next cycle, hi=9, lo=32'hFFFF_FFFF.
REQ-034 DIV started, flush_i at cycle 10 -> div_annul_o 1 cycle, no hilo_we_o, IDLE next cycle; back-to-back DIV then starts cleanly.
REQ-035 DIV_MAX_CYCLES=8 with div_ready_i never asserted -> timeout_o and div_annul_o pulse at cycle 8, then hilo_we_o with hi=lo=0.
REQ-036 rst asserted mid-DIV_WAIT -> all outputs 0 immediately (asynchronously), and state is IDLE after release.
